// File: rtl/sys_wload_pkg.sv
// sys_wload_pkg: FSM state type and sizing helpers for the weight-load sequencer
package sys_wload_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2, DONE = 2'd3} state_t;
  localparam int WL_ROWS = 4;
  localparam int WL_CW = $clog2(WL_ROWS + 1);
  function automatic int cnt_w(input int rows);
    return $clog2(rows + 1);
  endfunction
endpackage

// File: rtl/sys_wload_if.sv
// sys_wload_if: weight stream, shift chain and phase-controller signals; SYS_WLOAD_PARITY_EN adds wt_par/par_err
interface sys_wload_if #(parameter int DW = 8);
  logic load_en;
  logic wt_valid;
  logic [DW-1:0] wt_data;
  logic wt_ready;
  logic shift_en;
  logic [DW-1:0] shift_data;
  logic wt_latch;
  logic load_done;
  logic busy;
`ifdef SYS_WLOAD_PARITY_EN
  logic wt_par;
  logic par_err;
  modport master (output load_en, wt_valid, wt_data, wt_par,
                  input wt_ready, shift_en, shift_data, wt_latch, load_done, busy, par_err);
  modport slave (input load_en, wt_valid, wt_data, wt_par,
                 output wt_ready, shift_en, shift_data, wt_latch, load_done, busy, par_err);
`else
  modport master (output load_en, wt_valid, wt_data,
                  input wt_ready, shift_en, shift_data, wt_latch, load_done, busy);
  modport slave (input load_en, wt_valid, wt_data,
                 output wt_ready, shift_en, shift_data, wt_latch, load_done, busy);
`endif
endinterface

// File: rtl/sys_wload_fifo.sv
// sys_wload_fifo: small synchronous FIFO; push ignored when full, pop ignored when empty
module sys_wload_fifo #(
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [DW-1:0] wr_data_i,
  output logic full_o,
  output logic empty_o,
  output logic [DW-1:0] rd_data_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rd_data_o = mem_q[rp_q];
  // pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= do_push ? wp_q + AW'(1) : wp_q;
      rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset; entries are only read after being written
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= wr_data_i;
endmodule

// File: rtl/sys_wload_seq.sv
// sys_wload_seq: shifts ROWS buffered weights into the array chain, then commits; SYS_WLOAD_PARITY_EN adds parity checking
module sys_wload_seq
  import sys_wload_pkg::*;
#(
  parameter int DW = 8,
  parameter int ROWS = WL_ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  sys_wload_if.slave bus
);
  localparam int CW = cnt_w(ROWS);
`ifdef SYS_WLOAD_PARITY_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic en_q, shift_en_q, wt_latch_q, load_done_q;
  logic [DW-1:0] shift_data_q;
  logic [FW-1:0] wr_data, rd_data;
  logic full, empty, pop, all_in, fill_end;
`ifdef SYS_WLOAD_PARITY_EN
  logic par_err_q;
  assign wr_data = {bus.wt_par, bus.wt_data};
  assign bus.par_err = par_err_q;
  // a popped word with odd parity over {par, data} latches the error until reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_err_q <= 1'b0;
    else par_err_q <= par_err_q | (pop & ^rd_data);
`else
  assign wr_data = bus.wt_data;
`endif
  sys_wload_fifo #(.DW(FW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(bus.wt_valid),
    .pop_i(pop),
    .wr_data_i(wr_data),
    .full_o(full),
    .empty_o(empty),
    .rd_data_o(rd_data)
  );
  assign all_in = cnt_q == CW'(ROWS);
  assign pop = state_q == FILL && bus.load_en && !empty && !all_in;
  assign fill_end = state_q == FILL && bus.load_en && all_in;
  assign bus.wt_ready = !full;
  assign bus.shift_en = shift_en_q;
  assign bus.shift_data = shift_data_q;
  assign bus.wt_latch = wt_latch_q;
  assign bus.load_done = load_done_q;
  assign bus.busy = state_q != IDLE;
  // FILL lingers one cycle after the last pop so COMMIT follows the last shift_en
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      en_q <= 1'b0;
      shift_en_q <= 1'b0;
      shift_data_q <= '0;
      wt_latch_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      en_q <= bus.load_en;
      shift_en_q <= pop;
      shift_data_q <= pop ? rd_data[DW-1:0] : shift_data_q;
      wt_latch_q <= fill_end;
      load_done_q <= state_q == COMMIT;
      case (state_q)
        IDLE: begin
          state_q <= bus.load_en && !en_q ? FILL : IDLE;
          cnt_q <= '0;
        end
        FILL: begin
          state_q <= !bus.load_en ? IDLE : all_in ? COMMIT : FILL;
          cnt_q <= !bus.load_en ? '0 : pop ? cnt_q + CW'(1) : cnt_q;
        end
        COMMIT: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
endmodule
